// File: rtl/mux_arb_pkg.sv
// Shared types for the two-source round-robin mux arbiter.
// Holds the arbiter state encoding and source identifiers.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_A,
    ARB_GRANT_B
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2x1_bus.sv
// Combinational 2:1 bus mux.
// Ports: sel (0 = in0, 1 = in1), in0, in1, out (W bits).
module mux2x1_bus #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one registered output between
// sources A and B. Ports: a_*/b_* valid-ready inputs, sel, out_* register.
module mux2x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);

  arb_state_e state_q, state_d;
  logic       prio_q, prio_d;
  logic       can_load;
  logic       load;
  logic [DATA_W:0] mux_out;

  assign can_load = !out_valid || out_ready;

  mux2x1_bus #(
    .W (DATA_W + 1)
  ) u_bus (
    .sel (sel),
    .in0 ({a_last, a_data}),
    .in1 ({b_last, b_data}),
    .out (mux_out)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    sel     = SRC_A;
    load    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (a_valid && (!b_valid || prio_q == SRC_A))
          state_d = ARB_GRANT_A;
        else if (b_valid)
          state_d = ARB_GRANT_B;
      end
      ARB_GRANT_A: begin
        a_ready = can_load;
        load    = a_valid && can_load;
        if (load && a_last) begin
          state_d = ARB_IDLE;
          prio_d  = SRC_B;
        end
      end
      ARB_GRANT_B: begin
        sel     = SRC_B;
        b_ready = can_load;
        load    = b_valid && can_load;
        if (load && b_last) begin
          state_d = ARB_IDLE;
          prio_d  = SRC_A;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      prio_q  <= SRC_A;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // A load in the same cycle as a drain keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= SRC_A;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_out[DATA_W-1:0];
      out_last  <= mux_out[DATA_W];
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Scoreboard bench for mux2x1_rr_arbiter.
// Directed scenarios plus randomized traffic against a cycle reference model.
module tb_mux2x1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       sel;
  logic       out_valid, out_last, out_src, out_ready;
  logic [7:0] out_data;

  mux2x1_rr_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Source beat queues: {last, data}
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic       en_a = 0, en_b = 0, rnd = 0;
  logic       hs_a, hs_b;

  // Reference model: owner 0 = none, 1 = A, 2 = B
  int         m_owner = 0;
  logic       m_prio  = 0;
  logic       m_full  = 0;
  logic [9:0] exp_q[$];
  logic       src_log[$];

  initial begin
    logic can;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = 0;
        m_prio  = 0;
        m_full  = 0;
        exp_q.delete();
      end else begin
        logic ld;
        can = !m_full || out_ready;
        ld  = 1'b0;
        if (m_owner == 1) begin
          if (a_valid && can) begin
            ld = 1'b1;
            exp_q.push_back({1'b0, a_last, a_data});
            if (a_last) begin m_owner = 0; m_prio = 1; end
          end
        end else if (m_owner == 2) begin
          if (b_valid && can) begin
            ld = 1'b1;
            exp_q.push_back({1'b1, b_last, b_data});
            if (b_last) begin m_owner = 0; m_prio = 0; end
          end
        end else begin
          if (a_valid && b_valid) m_owner = m_prio ? 2 : 1;
          else if (a_valid)       m_owner = 1;
          else if (b_valid)       m_owner = 2;
        end
        if (ld)             m_full = 1'b1;
        else if (out_ready) m_full = 1'b0;
      end
    end
  end

  // Monitor: grant/ready checks and scoreboard pops
  initial begin
    logic can;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        can = !m_full || out_ready;
        chk("a_ready", a_ready, (m_owner == 1) && can);
        chk("b_ready", b_ready, (m_owner == 2) && can);
        chk("sel", sel, m_owner == 2);
        chk("out_valid", out_valid, m_full);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e[7:0]);
            chk("out_last", out_last, e[8]);
            chk("out_src", out_src, e[9]);
          end
          src_log.push_back(out_src);
        end
      end
    end
  end

  task automatic drive();
    a_valid = en_a && qa.size() != 0;
    b_valid = en_b && qb.size() != 0;
    if (qa.size() != 0) {a_last, a_data} = qa[0];
    else                {a_last, a_data} = '0;
    if (qb.size() != 0) {b_last, b_data} = qb[0];
    else                {b_last, b_data} = '0;
  endtask

  task automatic push_pkt(input logic s);
    int n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      logic [8:0] bt;
      bt = {i == n - 1, 8'($urandom)};
      if (s) qb.push_back(bt);
      else   qa.push_back(bt);
    end
  endtask

  // Call at a negedge: capture handshakes, advance sources after posedge
  task automatic tick();
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (hs_a) void'(qa.pop_front());
    if (hs_b) void'(qb.pop_front());
    if (rnd) begin
      if (qa.size() == 0 && $urandom_range(0, 2) == 0) push_pkt(0);
      if (qb.size() == 0 && $urandom_range(0, 2) == 0) push_pkt(1);
      en_a      = $urandom_range(0, 4) != 0;
      en_b      = $urandom_range(0, 4) != 0;
      out_ready = $urandom_range(0, 3) != 0;
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      tick();
    end
  endtask

  initial begin
    logic [7:0] d0;
    logic [7:0] ed;
    bit got;
    rst_n     = 0;
    out_ready = 0;
    drive();

    // 1: reset values with toggling inputs
    for (int i = 0; i < 6; i++) begin
      #3;
      a_valid   = 1'($urandom);
      b_valid   = 1'($urandom);
      a_data    = 8'($urandom);
      b_data    = 8'($urandom);
      a_last    = 1'($urandom);
      b_last    = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      chk("rst_outs",
          {sel, a_ready, b_ready, out_valid, out_last, out_src, out_data}, 0);
    end
    out_ready = 1;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    qa.push_back({1'b1, 8'h01});
    qb.push_back({1'b1, 8'h02});
    en_a = 1;
    en_b = 1;
    drive();
    @(negedge clk);
    chk("tie_idle", {a_ready, b_ready}, 0);
    tick();
    @(negedge clk);
    chk("tie_sel", sel, 0);
    chk("tie_a_ready", a_ready, 1);
    tick();
    run(6);

    // 2: single source latency and throughput
    qa.push_back({1'b0, 8'h11});
    qa.push_back({1'b0, 8'h22});
    qa.push_back({1'b1, 8'h33});
    drive();
    ed = 8'h11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("lat_a_ready", a_ready, c >= 1 && c <= 3);
      chk("lat_valid", out_valid, c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) begin
        chk("lat_data", out_data, ed);
        chk("lat_last", out_last, c == 4);
        chk("lat_src", out_src, 0);
        ed = ed + 8'h11;
      end
      tick();
    end

    // 5: lock holds while A idles mid-packet
    en_b = 0;
    qa.push_back({1'b0, 8'hAA});
    drive();
    run(2);
    en_a = 0;
    en_b = 1;
    qa.push_back({1'b1, 8'hBB});
    qb.push_back({1'b1, 8'h55});
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lock_b_ready", b_ready, 0);
      chk("lock_sel", sel, 0);
      tick();
    end
    en_a = 1;
    drive();
    @(negedge clk);
    chk("lock_a_ready", a_ready, 1);
    tick();
    @(negedge clk);
    chk("lock_idle", b_ready, 0);
    tick();
    @(negedge clk);
    chk("lock_b_sel", sel, 1);
    chk("lock_b_grant", b_ready, 1);
    tick();
    run(4);

    // 3: contention, two 2-beat packets per source
    src_log.delete();
    for (int p = 0; p < 2; p++) begin
      qa.push_back({1'b0, 8'(8'hA0 + p)});
      qa.push_back({1'b1, 8'(8'hA8 + p)});
      qb.push_back({1'b0, 8'(8'hB0 + p)});
      qb.push_back({1'b1, 8'(8'hB8 + p)});
    end
    drive();
    run(16);
    chk("order_len", src_log.size(), 8);
    for (int i = 0; i < 8 && i < src_log.size(); i++)
      chk("order_src", src_log[i], (i / 2) % 2);

    // 4: backpressure
    en_b = 0;
    qa.push_back({1'b0, 8'h41});
    qa.push_back({1'b0, 8'h42});
    qa.push_back({1'b1, 8'h43});
    drive();
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = out_valid;
      tick();
    end
    chk("bp_fill", got, 1);
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) d0 = out_data;
      else chk("bp_stable", out_data, d0);
      chk("bp_hold", out_valid, 1);
      chk("bp_a_ready", a_ready, 0);
      tick();
    end
    out_ready = 1;
    run(8);
    chk("bp_drained", qa.size() + exp_q.size(), 0);

    // random traffic
    rnd = 1;
    run(3000);
    rnd = 0;
    en_a = 1;
    en_b = 1;
    out_ready = 1;
    drive();
    for (int c = 0; c < 200 && (qa.size() + qb.size()) != 0; c++) run(1);
    run(4);
    chk("rnd_drained", qa.size() + qb.size() + exp_q.size(), 0);

    // 6: async reset mid-packet of B
    en_a = 0;
    en_b = 1;
    for (int i = 0; i < 4; i++) qb.push_back({i == 3, 8'(8'hC0 + i)});
    drive();
    run(4);
    #2;
    rst_n = 0;
    #1;
    chk("arst_outs",
        {sel, a_ready, b_ready, out_valid, out_last, out_src, out_data}, 0);
    qa.delete();
    qb.delete();
    en_b = 0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1;
    qa.push_back({1'b1, 8'h5A});
    qb.push_back({1'b1, 8'hA5});
    en_a = 1;
    en_b = 1;
    drive();
    @(negedge clk);
    chk("arst_idle", {a_ready, b_ready}, 0);
    tick();
    @(negedge clk);
    chk("arst_tie_sel", sel, 0);
    chk("arst_tie_a", a_ready, 1);
    tick();
    run(6);
    chk("end_drained", exp_q.size() + qa.size() + qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
